post_port: RTL and testbench
============================

POST_PORT -- requirements
Module: post_port

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 words (16).
REQ-002 wb_clk_i  input  1  sole clock; all state on rising edge.
REQ-003 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 wb_dat_i  input  16  Wishbone write data from CPU.
REQ-005 wb_dat_o  output  16  Wishbone read data.
REQ-006 wb_adr_i  input  15  word address [15:1]; only bit 1 decoded (0 = DATA at F100h, 1 = STAT at F102h); upper decode is external via stb gating.
REQ-007 wb_we_i  input  1  write strobe.
REQ-008 wb_tga_i  input  1  1 = I/O cycle, 0 = memory cycle.
REQ-009 wb_sel_i  input  2  byte lanes [1]=high, [0]=low.
REQ-010 wb_stb_i, wb_cyc_i  input  1 each  cycle request; access valid when both high.
REQ-011 wb_ack_o  output  1  cycle acknowledge.
REQ-012 dat_o  output  16  FIFO head word for local consumer (LCD/debug).
REQ-013 valid_o  output  1  FIFO non-empty.
REQ-014 pop_i  input  1  consumer pops head on clock edge when valid_o high.
REQ-015 ovf_o  output  1  sticky overflow flag.

Function
REQ-016 Handshake: two states, IDLE and ACK; IDLE->ACK when stb&cyc&!ack; ACK->IDLE unconditionally; wb_ack_o high exactly in ACK, one cycle per access, even if stb held.
REQ-017 Side effects (push, register update, clear) occur once, on the IDLE->ACK edge; none in ACK.
REQ-018 Memory cycles (tga=0): acknowledged, no side effect, wb_dat_o = 0000h.
REQ-019 DATA write: last-value register LAST updated per byte lane (sel[1] -> [15:8], sel[0] -> [7:0]); merged word pushed to FIFO; sel=00 acks with no push, no update.
REQ-020 DATA read: wb_dat_o = LAST, registered, valid while wb_ack_o high; no pop.
REQ-021 STAT read: wb_dat_o = {ovf, 10'b0, count[4:0]}, count = occupancy 0..16.
REQ-022 STAT write with sel[0]=1 and wb_dat_i[0]=1: FIFO emptied, ovf cleared; other bits ignored; LAST unchanged.
REQ-023 Push when count=16 and no same-cycle pop: word dropped, ovf_o set, count stays 16.
REQ-024 Push and pop same edge: both succeed, count unchanged (including count=16: no overflow).
REQ-025 Pop with count=0: ignored; count never underflows.
REQ-026 Clear and pop/push same edge: clear wins; count=0 after edge.
REQ-027 dat_o show-ahead: equals oldest unread word whenever valid_o=1; value undefined-but-stable when empty; valid_o = (count!=0), combinational from registered count.
REQ-028 Read/write pointers DEPTH_LOG2 bits, wrap modulo depth; count DEPTH_LOG2+1 bits.
REQ-029 Storage: register array or distributed RAM, synchronous write, asynchronous read.

Reset
REQ-030 While wb_rst_i high: state IDLE, wb_ack_o=0, wb_dat_o=0000h, LAST=0000h, pointers=0, count=0, valid_o=0, ovf_o=0.
REQ-031 Reset mid-cycle (ACK state) aborts: wb_ack_o drops immediately (async); pending access discarded; FIFO contents lost.
REQ-032 First access accepted on the first edge after wb_rst_i deasserts.

Verification
REQ-033 Write DATA 1234h sel=11, then read DATA -> ack one cycle each, read returns 1234h, valid_o=1, dat_o=1234h, STAT=0001h.
REQ-034 Hold stb&cyc high 6 cycles on DATA write ABCDh -> ack pattern 0,1,0,1,0,1; three pushes; STAT=0003h.
REQ-035 17 DATA writes 0000h..0010h, no pops -> STAT=8010h, ovf_o=1, pop 16 times yields 0000h..000Fh in order, then valid_o=0.
REQ-036 Count=16, push 5555h with pop_i=1 same edge -> count 16, ovf_o=0, last popped-in word 5555h at tail.
REQ-037 LAST=1234h, write DATA 00FFh sel=01 -> LAST=12FFh, pushed 12FFh; write STAT 0001h -> count 0, ovf 0, valid_o=0.
REQ-038 Assert wb_rst_i during ACK with count=5 -> wb_ack_o=0 same cycle, count=0, valid_o=0, ovf_o=0.

Source files
------------

// File: rtl/post_port_if.sv
// post_port_if -- Wishbone slave bus bundle for the POST code port.
//
// Groups the CPU-side Wishbone signals of post_port so the bus can be
// passed around as one port.
//   wb_dat_i  [15:0]  write data from the CPU
//   wb_dat_o  [15:0]  read data to the CPU
//   wb_adr_i  [15:1]  word address (only bit 1 is decoded by the port)
//   wb_we_i           write strobe
//   wb_tga_i          1 = I/O cycle, 0 = memory cycle
//   wb_sel_i  [1:0]   byte lanes, [1] = high byte, [0] = low byte
//   wb_stb_i/wb_cyc_i cycle request, access valid when both are high
//   wb_ack_o          cycle acknowledge
// The master modport is the CPU side and the slave modport is the port.
interface post_port_if;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [15:1] wb_adr_i;
  logic        wb_we_i;
  logic        wb_tga_i;
  logic [1:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport master (
    output wb_dat_i, wb_adr_i, wb_we_i, wb_tga_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_dat_i, wb_adr_i, wb_we_i, wb_tga_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/post_port.sv
// post_port -- POST code capture port with a show-ahead FIFO.
//
// The CPU writes POST codes to the DATA register (I/O F100h); each write
// updates a byte-lane-merged "last value" register and pushes the merged
// word into a FIFO that a local consumer (LCD/debug) drains. The STAT
// register (I/O F102h) reports {overflow, occupancy} and a write of bit 0
// empties the FIFO and clears the overflow flag.
//   wb_clk_i         sole clock, rising edge
//   wb_rst_i         asynchronous active-high reset
//   bus              Wishbone slave (post_port_if.slave)
//   dat_o   [15:0]   FIFO head word (show-ahead)
//   valid_o          FIFO non-empty
//   pop_i            consumer pops the head on a clock edge when valid_o is high
//   ovf_o            sticky overflow flag
module post_port #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  post_port_if.slave   bus,
  output logic [15:0]  dat_o,
  output logic         valid_o,
  input  logic         pop_i,
  output logic         ovf_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic [15:0]           rdat_q, rdat_d;
  logic [15:0]           last_q, last_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic [15:0] mem [DEPTH];

  logic        access;
  logic        data_wr;
  logic        stat_clr;
  logic        push_en;
  logic        pop_en;
  logic [15:0] merged;
  logic [15:0] stat_word;
  logic        unused_adr;

  // Upper address bits are decoded externally through stb gating.
  assign unused_adr = ^bus.wb_adr_i[15:2];

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    rdat_d   = 16'h0000;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    push_en  = 1'b0;
    pop_en   = 1'b0;

    // An access is taken only from IDLE, so a held strobe is acked every
    // other cycle and side effects happen once per acknowledge.
    access    = bus.wb_stb_i & bus.wb_cyc_i & (state_q == IDLE);
    data_wr   = access & bus.wb_tga_i & bus.wb_we_i & ~bus.wb_adr_i[1] & (|bus.wb_sel_i);
    stat_clr  = access & bus.wb_tga_i & bus.wb_we_i & bus.wb_adr_i[1]
                & bus.wb_sel_i[0] & bus.wb_dat_i[0];
    merged    = {bus.wb_sel_i[1] ? bus.wb_dat_i[15:8] : last_q[15:8],
                 bus.wb_sel_i[0] ? bus.wb_dat_i[7:0]  : last_q[7:0]};
    stat_word = {ovf_q, 15'(count_q)};

    case (state_q)
      IDLE: if (access) begin
        state_d = ACK;
        ack_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Read data is registered and presented together with the acknowledge;
    // memory cycles and writes return zero.
    if (access && bus.wb_tga_i && !bus.wb_we_i)
      rdat_d = bus.wb_adr_i[1] ? stat_word : last_q;

    if (data_wr)
      last_d = merged;

    if (stat_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      pop_en  = pop_i & (count_q != '0);
      // A full FIFO still accepts a push when the head leaves on the same
      // edge; the freed slot is the one the write pointer already targets.
      push_en = data_wr & ((count_q != FULL) | pop_en);
      if (data_wr && !push_en)
        ovf_d = 1'b1;
      if (push_en)
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop_en)
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state and registered bus outputs; reset aborts any access in
  // flight and discards the FIFO by zeroing pointers and count.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      rdat_q   <= 16'h0000;
      last_q   <= 16'h0000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage: synchronous write, asynchronous read of the head.
  always_ff @(posedge wb_clk_i) begin
    if (push_en)
      mem[wr_ptr_q] <= merged;
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = rdat_q;
  assign dat_o        = mem[rd_ptr_q];
  assign valid_o      = (count_q != '0);
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_post_port.sv
// tb_post_port -- directed self-checking bench for post_port.
//
// Drives Wishbone accesses and consumer pops as a linear sequence of
// directed steps with hand-computed expected values. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge or
// on the falling edge.
module tb_post_port;

  logic        clk;
  logic        rst;
  logic [15:0] dat_o;
  logic        valid_o;
  logic        pop_i;
  logic        ovf_o;

  int checks;
  int failures;

  post_port_if bus ();

  post_port #(.DEPTH_LOG2(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus.slave),
    .dat_o    (dat_o),
    .valid_o  (valid_o),
    .pop_i    (pop_i),
    .ovf_o    (ovf_o)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive the bus request lines.
  task automatic applyStimulus(input logic tga, input logic we, input logic adr1,
                               input logic [1:0] sel, input logic [15:0] dat);
    bus.wb_tga_i = tga;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr1 ? 15'h7881 : 15'h7880;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
  endtask

  task automatic bus_idle();
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  // One complete single-cycle Wishbone access; checks the acknowledge and
  // returns the data presented with it.
  task automatic wb_access(input logic tga, input logic we, input logic adr1,
                           input logic [1:0] sel, input logic [15:0] dat,
                           output logic [15:0] rdata);
    @(negedge clk);
    applyStimulus(tga, we, adr1, sel, dat);
    @(posedge clk);
    #1;
    checkOutput("ack", 16'(bus.wb_ack_o), 16'h0001);
    rdata = bus.wb_dat_o;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic clear_fifo();
    logic [15:0] r;
    wb_access(1'b1, 1'b1, 1'b1, 2'b01, 16'h0001, r);
  endtask

  task automatic read_stat(output logic [15:0] r);
    wb_access(1'b1, 1'b0, 1'b1, 2'b11, 16'h0000, r);
  endtask

  task automatic write_data(input logic [1:0] sel, input logic [15:0] dat);
    logic [15:0] r;
    wb_access(1'b1, 1'b1, 1'b0, sel, dat, r);
  endtask

  // Check the head word, then pop it on the next rising edge.
  task automatic pop_check(input string tag, input logic [15:0] expected);
    @(negedge clk);
    checkOutput(tag, dat_o, expected);
    pop_i = 1'b1;
    @(negedge clk);
    pop_i = 1'b0;
  endtask

  logic [15:0] rd;
  logic [5:0]  ack_pattern;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    pop_i    = 1'b0;
    bus.wb_dat_i = 16'h0000;
    bus.wb_adr_i = 15'h7880;
    bus.wb_tga_i = 1'b0;
    bus.wb_sel_i = 2'b00;
    bus_idle();

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_ack", 16'(bus.wb_ack_o), 16'h0000);
    checkOutput("rst_rdat", bus.wb_dat_o, 16'h0000);
    checkOutput("rst_valid", 16'(valid_o), 16'h0000);
    checkOutput("rst_ovf", 16'(ovf_o), 16'h0000);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic write then read of DATA.
    write_data(2'b11, 16'h1234);
    wb_access(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, rd);
    checkOutput("data_rd", rd, 16'h1234);
    checkOutput("valid_1", 16'(valid_o), 16'h0001);
    checkOutput("head_1", dat_o, 16'h1234);
    read_stat(rd);
    checkOutput("stat_1", rd, 16'h0001);

    // Memory cycles are acked with zero data and no side effect.
    wb_access(1'b0, 1'b0, 1'b0, 2'b11, 16'h0000, rd);
    checkOutput("mem_rd", rd, 16'h0000);
    wb_access(1'b0, 1'b1, 1'b0, 2'b11, 16'hFFFF, rd);
    read_stat(rd);
    checkOutput("mem_wr_stat", rd, 16'h0001);
    wb_access(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, rd);
    checkOutput("mem_wr_last", rd, 16'h1234);

    // Held strobe: one acknowledge every other cycle, one push per ack.
    clear_fifo();
    ack_pattern = 6'b101010;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 16'hABCD);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("hold_ack%0d", i), 16'(bus.wb_ack_o), 16'(ack_pattern[i]));
      @(negedge clk);
    end
    bus_idle();
    @(negedge clk);
    read_stat(rd);
    checkOutput("hold_stat", rd, 16'h0003);

    // Overflow: 17 writes into a 16-deep FIFO.
    clear_fifo();
    for (int i = 0; i < 17; i++)
      write_data(2'b11, 16'(i));
    read_stat(rd);
    checkOutput("ovf_stat", rd, 16'h8010);
    checkOutput("ovf_flag", 16'(ovf_o), 16'h0001);
    for (int i = 0; i < 16; i++)
      pop_check($sformatf("ovf_pop%0d", i), 16'(i));
    checkOutput("ovf_empty", 16'(valid_o), 16'h0000);
    read_stat(rd);
    checkOutput("ovf_sticky", rd, 16'h8000);

    // Pop while empty must not underflow.
    @(negedge clk);
    pop_i = 1'b1;
    @(negedge clk);
    pop_i = 1'b0;
    read_stat(rd);
    checkOutput("underflow", rd, 16'h8000);

    // Reset during an acknowledge with five words queued and ovf set.
    for (int i = 0; i < 4; i++)
      write_data(2'b11, 16'h0A00 + 16'(i));
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 16'h0A04);
    @(posedge clk);
    #1;
    checkOutput("mid_ack", 16'(bus.wb_ack_o), 16'h0001);
    checkOutput("mid_valid", 16'(valid_o), 16'h0001);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ack", 16'(bus.wb_ack_o), 16'h0000);
    checkOutput("mid_rst_valid", 16'(valid_o), 16'h0000);
    checkOutput("mid_rst_ovf", 16'(ovf_o), 16'h0000);
    bus_idle();
    @(posedge clk);
    #1 rst = 1'b0;
    read_stat(rd);
    checkOutput("post_rst_stat", rd, 16'h0000);
    wb_access(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, rd);
    checkOutput("post_rst_last", rd, 16'h0000);

    // Push and pop on the same edge while full: no overflow.
    for (int i = 0; i < 16; i++)
      write_data(2'b11, 16'h0100 + 16'(i));
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 16'h5555);
    pop_i = 1'b1;
    @(negedge clk);
    pop_i = 1'b0;
    bus_idle();
    read_stat(rd);
    checkOutput("full_pp_stat", rd, 16'h0010);
    checkOutput("full_pp_ovf", 16'(ovf_o), 16'h0000);
    for (int i = 0; i < 16; i++)
      pop_check($sformatf("full_pp_pop%0d", i), (i < 15) ? 16'h0101 + 16'(i) : 16'h5555);

    // Byte-lane merging into LAST and the pushed word.
    write_data(2'b11, 16'h1234);
    write_data(2'b01, 16'h00FF);
    wb_access(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, rd);
    checkOutput("lane_lo_last", rd, 16'h12FF);
    write_data(2'b10, 16'hAB77);
    write_data(2'b00, 16'h9999);
    wb_access(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, rd);
    checkOutput("lane_hi_last", rd, 16'hABFF);
    // STAT write without bit 0 is ignored.
    wb_access(1'b1, 1'b1, 1'b1, 2'b11, 16'hFFFE, rd);
    read_stat(rd);
    checkOutput("lane_stat", rd, 16'h0003);
    pop_check("lane_head0", 16'h1234);
    checkOutput("lane_head1", dat_o, 16'h12FF);

    // Clear wins over a same-edge pop.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 16'h0001);
    pop_i = 1'b1;
    @(negedge clk);
    pop_i = 1'b0;
    bus_idle();
    checkOutput("clr_valid", 16'(valid_o), 16'h0000);
    read_stat(rd);
    checkOutput("clr_stat", rd, 16'h0000);
    wb_access(1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, rd);
    checkOutput("clr_last", rd, 16'hABFF);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
